// File: rtl/multiword_add_sequencer_if.sv
// Command/status bundle for multiword_add_sequencer; the i_sub line exists only when SUB_EN is defined.
interface multiword_add_sequencer_if #(parameter int WORDS = 4);
  logic                  i_start;
  logic [WORDS*16-1:0]   i_a;
  logic [WORDS*16-1:0]   i_b;
`ifdef SUB_EN
  logic                  i_sub;
`endif
  logic                  o_busy;
  logic                  o_done;
  logic [WORDS*16-1:0]   o_sum;
  logic                  o_sign;
  logic                  o_zero;
  logic                  o_overflow;
  logic                  o_carry;
  logic                  o_parity;

  modport master (
`ifdef SUB_EN
    output i_sub,
`endif
    output i_start, i_a, i_b,
    input  o_busy, o_done, o_sum, o_sign, o_zero, o_overflow, o_carry, o_parity
  );

  modport slave (
`ifdef SUB_EN
    input  i_sub,
`endif
    input  i_start, i_a, i_b,
    output o_busy, o_done, o_sum, o_sign, o_zero, o_overflow, o_carry, o_parity
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Word-serial WORDS*16-bit adder built around one shared 16-bit adder, LS word first.
// Define SUB_EN to add the subtract select (A + ~B + 1, carry=1 means no borrow).
module multiword_add_sequencer #(
  parameter int WORDS = 4
) (
  input logic                    clk,
  input logic                    rst,
  multiword_add_sequencer_if.slave bus
);

  localparam int W  = WORDS * 16;
  localparam int SW = (WORDS - 1) * 16;
  localparam int IW = $clog2(WORDS);

  typedef enum logic {IDLE, RUN} state_e;

  state_e          r_state;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [SW-1:0]   r_shadow;
`ifdef SUB_EN
  logic            r_sub;
`endif
  logic [W-1:0]    r_sum;
  logic            r_done;
  logic            r_sign;
  logic            r_zero;
  logic            r_overflow;
  logic            r_carryFlag;
  logic            r_parity;

  logic            w_invert;
  logic            w_startCarry;
  logic [15:0]     w_aWord;
  logic [15:0]     w_bWord;
  logic [16:0]     w_wordSum;
  logic [W-1:0]    w_fullSum;
  logic            w_lastWord;

`ifdef SUB_EN
  assign w_invert     = r_sub;
  assign w_startCarry = bus.i_sub;
`else
  assign w_invert     = 1'b0;
  assign w_startCarry = 1'b0;
`endif

  // Operands shift right each word, so the adder always sees the low word.
  assign w_aWord    = r_a[15:0];
  assign w_bWord    = r_b[15:0] ^ {16{w_invert}};
  assign w_wordSum  = {1'b0, w_aWord} + {1'b0, w_bWord} + {16'd0, r_carry};
  assign w_fullSum  = {w_wordSum[15:0], r_shadow};
  assign w_lastWord = (r_idx == IW'(WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_shadow    <= '0;
`ifdef SUB_EN
      r_sub       <= 1'b0;
`endif
      r_sum       <= '0;
      r_done      <= 1'b0;
      r_sign      <= 1'b0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_carryFlag <= 1'b0;
      r_parity    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_a     <= bus.i_a;
            r_b     <= bus.i_b;
`ifdef SUB_EN
            r_sub   <= bus.i_sub;
`endif
            r_carry <= w_startCarry;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          // Finished words enter the shadow at the top and drift down toward word 0.
          r_shadow <= SW'({w_wordSum[15:0], r_shadow} >> 16);
          r_a      <= r_a >> 16;
          r_b      <= r_b >> 16;
          r_carry  <= w_wordSum[16];
          r_idx    <= r_idx + 1'b1;
          if (w_lastWord) begin
            r_state     <= IDLE;
            r_done      <= 1'b1;
            r_sum       <= w_fullSum;
            r_sign      <= w_wordSum[15];
            r_zero      <= ~|w_fullSum;
            r_parity    <= ~^w_fullSum;
            r_carryFlag <= w_wordSum[16];
            r_overflow  <= (w_aWord[15] == w_bWord[15]) && (w_wordSum[15] != w_aWord[15]);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_busy     = (r_state == RUN);
  assign bus.o_done     = r_done;
  assign bus.o_sum      = r_sum;
  assign bus.o_sign     = r_sign;
  assign bus.o_zero     = r_zero;
  assign bus.o_overflow = r_overflow;
  assign bus.o_carry    = r_carryFlag;
  assign bus.o_parity   = r_parity;

endmodule
